sdram_request_arbiter: RTL

Two-port arbiter and transaction sequencer in front of the single-access SDRAM controller. It owns the controller's command interface (address, write data, read/write select, start pulse), grants it round-robin between requester 0 and requester 1, and returns read data or write completion to the owner. A guard interval and a watchdog stop commands from being issued while the controller is still finishing an access, and stop the arbiter from hanging if the controller stalls.

---
 rtl/sdram_request_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sdram_request_arbiter.sv
// sdram_request_arbiter
//   Two-port round-robin arbiter and transaction sequencer that owns the
//   command interface of a single-access SDRAM controller.
//
//   Parameters
//     GUARD_CYCLES   idle cycles after completion before the next issue (1..15)
//     TIMEOUT_CYCLES watchdog limit from issue to completion (8-bit)
//
//   Ports
//     max10Board_SDRAM_Clock  clock, rising edge
//     reset_n                 synchronous, active-low reset
//     reqN/addrN/wdataN/weN   requester N command (level request)
//     ackN                    pulse: request latched and issued
//     doneN                   pulse: transaction complete (or timed out)
//     rdataN                  read data, held until the next read by port N
//     ctrl_*                  controller command/status interface
//     timeout_err             sticky watchdog-expiry flag
//     owner                   port that owns the current/last transaction
module sdram_request_arbiter #(
    parameter int unsigned GUARD_CYCLES   = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        max10Board_SDRAM_Clock,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [24:0] addr0,
    input  logic [24:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    input  logic        we0,
    input  logic        we1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic [24:0] ctrl_address,
    output logic [15:0] ctrl_inputData,
    output logic        ctrl_isWriting,
    output logic        ctrl_inputValid,
    input  logic        ctrl_isBusy,
    input  logic        ctrl_outputValid,
    input  logic [15:0] ctrl_outputData,
    output logic        timeout_err,
    output logic        owner
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_ACCEPT,
        S_WAIT_DONE,
        S_GUARD
    } state_t;

    state_t      r_state;
    logic        r_last;
    logic [7:0]  r_wd;
    logic [3:0]  r_guard;
    logic        r_ack0, r_ack1, r_done0, r_done1;
    logic [15:0] r_rdata0, r_rdata1;
    logic [24:0] r_address;
    logic [15:0] r_inputData;
    logic        r_isWriting, r_inputValid, r_timeout, r_owner;

    logic w_grant1;
    logic w_waiting;
    logic w_finish;
    logic w_expired;

    // Port 1 wins when it is the only requester, or on a tie when port 0
    // was served last.
    assign w_grant1  = req1 && (!req0 || !r_last);
    assign w_waiting = (r_state == S_WAIT_ACCEPT) || (r_state == S_WAIT_DONE);
    assign w_finish  = (r_state == S_WAIT_DONE) &&
                       (r_isWriting ? !ctrl_isBusy : ctrl_outputValid);
    assign w_expired = w_waiting && !w_finish && (r_wd == 8'(TIMEOUT_CYCLES));

    always_ff @(posedge max10Board_SDRAM_Clock) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last       <= 1'b1;
            r_wd         <= '0;
            r_guard      <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_address    <= '0;
            r_inputData  <= '0;
            r_isWriting  <= 1'b0;
            r_inputValid <= 1'b0;
            r_timeout    <= 1'b0;
            r_owner      <= 1'b0;
        end else begin
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_inputValid <= 1'b0;

            // Watchdog clears during the start-pulse cycle and counts every
            // cycle after it, so expiry lands TIMEOUT_CYCLES + 2 after ack.
            if (w_waiting) begin
                if (r_inputValid) r_wd <= '0;
                else              r_wd <= r_wd + 8'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (!ctrl_isBusy && (req0 || req1)) begin
                        r_owner      <= w_grant1;
                        r_address    <= w_grant1 ? addr1  : addr0;
                        r_inputData  <= w_grant1 ? wdata1 : wdata0;
                        r_isWriting  <= w_grant1 ? we1    : we0;
                        r_ack0       <= !w_grant1;
                        r_ack1       <= w_grant1;
                        r_inputValid <= 1'b1;
                        r_wd         <= '0;
                        r_state      <= S_WAIT_ACCEPT;
                    end
                end
                S_WAIT_ACCEPT: begin
                    if (ctrl_isBusy) r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: ;
                S_GUARD: begin
                    if (r_guard == 4'd0) r_state <= S_IDLE;
                    else                 r_guard <= r_guard - 4'd1;
                end
                default: r_state <= S_IDLE;
            endcase

            // Completion and watchdog expiry share the hand-off to GUARD;
            // only a real read completion updates rdata.
            if (w_finish || w_expired) begin
                r_done0 <= !r_owner;
                r_done1 <= r_owner;
                r_last  <= r_owner;
                r_guard <= 4'(GUARD_CYCLES - 1);
                r_state <= S_GUARD;
                if (w_expired) r_timeout <= 1'b1;
                if (w_finish && !r_isWriting) begin
                    if (r_owner) r_rdata1 <= ctrl_outputData;
                    else         r_rdata0 <= ctrl_outputData;
                end
            end
        end
    end

    assign ack0            = r_ack0;
    assign ack1            = r_ack1;
    assign done0           = r_done0;
    assign done1           = r_done1;
    assign rdata0          = r_rdata0;
    assign rdata1          = r_rdata1;
    assign ctrl_address    = r_address;
    assign ctrl_inputData  = r_inputData;
    assign ctrl_isWriting  = r_isWriting;
    assign ctrl_inputValid = r_inputValid;
    assign timeout_err     = r_timeout;
    assign owner           = r_owner;

endmodule
